// File: rtl/ibex_fetch_req_ctrl.sv
// ibex_fetch_req_ctrl: instruction-fetch request controller.
// Issues word-aligned requests on a req/gnt/rvalid bus, tracks up to NUM_REQS
// outstanding transactions plus buffered responses, drops responses that are
// stale after a branch, and forwards live words with their addresses to the
// fetch FIFO. Optional macro FETCH_ERR_EN adds bus-error ports. When it is
// set, the error bit travels with each word, and a live error stops new
// requests until the next branch.
`timescale 1ns/1ps
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_valid_o,
  input  logic        fifo_ready_i,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
`ifdef FETCH_ERR_EN
  input  logic        instr_err_i,
  output logic        fifo_err_o,
`endif
  output logic        fifo_clear_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [CW:0]   NUM_REQS_W = (CW + 1)'(NUM_REQS);
  localparam logic [PW-1:0] LAST_PTR   = PW'(NUM_REQS - 1);

  logic          started_q;
  logic          req_hold_q;
  logic [31:0]   fetch_addr_q;
  logic [31:0]   rsp_addr_q;
  logic [CW-1:0] out_cnt_q;
  logic [CW-1:0] disc_cnt_q;
  logic [CW-1:0] buf_cnt_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;

  logic [31:0]   buf_addr_q [NUM_REQS];
  logic [31:0]   buf_data_q [NUM_REQS];

  logic [CW:0]   occupancy;
  logic          can_issue;
  logic          grant;
  logic          rsp_valid;
  logic          live;
  logic          buf_empty;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          issue_block;
  logic          unused_addr0;

  assign unused_addr0 = addr_i[0];

`ifdef FETCH_ERR_EN
  logic buf_err_q [NUM_REQS];
  logic err_lock_q;
  assign issue_block = err_lock_q;
`else
  assign issue_block = 1'b0;
`endif

  // Request issue: new requests need space reserved for every granted word;
  // a raised request stays up until granted. A branch retargets it in place.
  always_comb begin
    occupancy    = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q};
    can_issue    = req_i && (occupancy < NUM_REQS_W) && (started_q || branch_i) &&
                   (!issue_block || branch_i);
    instr_req_o  = req_hold_q || can_issue;
    instr_addr_o = branch_i ? {addr_i[31:2], 2'b00} : fetch_addr_q;
    grant        = instr_req_o && instr_gnt_i;
    busy_o       = instr_req_o || (out_cnt_q != '0) || (buf_cnt_q != '0);
    fifo_clear_o = branch_i;
  end

  // Response classification and the bypass/buffer routing decision.
  always_comb begin
    rsp_valid = instr_rvalid_i && (out_cnt_q != '0);
    live      = rsp_valid && (disc_cnt_q == '0) && !branch_i;
    buf_empty = (buf_cnt_q == '0);
    bypass    = live && buf_empty && fifo_ready_i;
    push      = live && !bypass;
    pop       = !branch_i && !buf_empty && fifo_ready_i;
  end

  // FIFO-side outputs: zero-latency bypass when possible, else buffer head.
  always_comb begin
    fifo_valid_o = !branch_i && (bypass || !buf_empty);
    fifo_addr_o  = bypass ? rsp_addr_q    : buf_addr_q[rd_ptr_q];
    fifo_rdata_o = bypass ? instr_rdata_i : buf_data_q[rd_ptr_q];
`ifdef FETCH_ERR_EN
    fifo_err_o   = fifo_valid_o && (bypass ? instr_err_i : buf_err_q[rd_ptr_q]);
`endif
  end

  // Request address, hold and boot-enable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q    <= 1'b0;
      req_hold_q   <= 1'b0;
      fetch_addr_q <= '0;
    end else begin
      started_q  <= started_q || branch_i;
      req_hold_q <= instr_req_o && !instr_gnt_i;
      if (grant) begin
        fetch_addr_q <= instr_addr_o + 32'd4;
      end else if (branch_i) begin
        fetch_addr_q <= {addr_i[31:2], 2'b00};
      end
    end
  end

  // Outstanding/discard counters and the live response address.
  // disc_cnt excludes a response arriving in the branch cycle itself, since
  // that one is consumed (and dropped) right here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      rsp_addr_q <= '0;
    end else begin
      case ({grant, rsp_valid})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
      if (branch_i) begin
        disc_cnt_q <= out_cnt_q - {{(CW-1){1'b0}}, rsp_valid};
        rsp_addr_q <= {addr_i[31:1], 1'b0};
      end else begin
        if (rsp_valid && (disc_cnt_q != '0)) begin
          disc_cnt_q <= disc_cnt_q - 1'b1;
        end
        if (live) begin
          rsp_addr_q <= {rsp_addr_q[31:2] + 30'd1, 2'b00};
        end
      end
    end
  end

  // Response buffer bookkeeping; a branch flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else if (branch_i) begin
      buf_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      case ({push, pop})
        2'b10:   buf_cnt_q <= buf_cnt_q + 1'b1;
        2'b01:   buf_cnt_q <= buf_cnt_q - 1'b1;
        default: buf_cnt_q <= buf_cnt_q;
      endcase
      if (push) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Buffer storage; contents are only observed through the counted head.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr_q[wr_ptr_q] <= rsp_addr_q;
      buf_data_q[wr_ptr_q] <= instr_rdata_i;
`ifdef FETCH_ERR_EN
      buf_err_q[wr_ptr_q]  <= instr_err_i;
`endif
    end
  end

`ifdef FETCH_ERR_EN
  // Error lock: a live erroneous word blocks new requests until a branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_lock_q <= 1'b0;
    end else if (branch_i) begin
      err_lock_q <= 1'b0;
    end else if (live && instr_err_i) begin
      err_lock_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Bench for ibex_fetch_req_ctrl: vector table, directed multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ibex_fetch_req_ctrl;
  localparam int unsigned N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        busy_o, instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fifo_valid_o;
  logic        fifo_ready_i = 1'b0;
  logic [31:0] fifo_addr_o, fifo_rdata_o;
  logic        fifo_clear_o;
`ifdef FETCH_ERR_EN
  logic        err_in = 1'b0;
  logic        fifo_err_o;
`endif

  always #5 clk = ~clk;

  ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .busy_o(busy_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fifo_valid_o(fifo_valid_o), .fifo_ready_i(fifo_ready_i), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o),
`ifdef FETCH_ERR_EN
    .instr_err_i(err_in), .fifo_err_o(fifo_err_o),
`endif
    .fifo_clear_o(fifo_clear_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic apply(input logic rq, input logic br, input logic [31:0] a, input logic g,
                       input logic rv, input logic [31:0] d, input logic rd);
    req_i = rq; branch_i = br; addr_i = a; instr_gnt_i = g;
    instr_rvalid_i = rv; instr_rdata_i = d; fifo_ready_i = rd;
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic drive(input logic rq, input logic br, input logic [31:0] a, input logic g,
                       input logic rv, input logic [31:0] d, input logic rd);
    @(posedge clk); #1;
    apply(rq, br, a, g, rv, d, rd);
    @(negedge clk);
  endtask

`ifdef FETCH_ERR_EN
  task automatic drive_e(input logic rq, input logic br, input logic [31:0] a, input logic g,
                         input logic rv, input logic [31:0] d, input logic rd, input logic e);
    @(posedge clk); #1;
    err_in = e;
    apply(rq, br, a, g, rv, d, rd);
    @(negedge clk);
  endtask
`endif

  typedef struct {
    logic rq; logic br; logic [31:0] a; logic g; logic rv; logic [31:0] d; logic rd;
    logic e_req; logic [31:0] e_iaddr; logic e_fv; logic [31:0] e_faddr; logic [31:0] e_fdata;
    logic e_busy;
  } vec_t;

  // Transaction-level reference model state.
  typedef struct { logic [31:0] addr; int unsigned ep; } out_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } word_t;
  out_t        outq[$];
  word_t       expq[$];
  int unsigned m_epoch;
  logic        m_hold, m_started;
  logic [31:0] m_fetch, m_rsp;

  task automatic model_reset();
    outq.delete(); expq.delete();
    m_epoch = 0; m_hold = 1'b0; m_started = 1'b0; m_fetch = '0; m_rsp = '0;
  endtask

  task automatic model_step();
    int unsigned occ;
    logic        e_req;
    out_t        e;
    word_t       w;
    occ = outq.size() + expq.size();
    chk("fifo_clear", fifo_clear_o, branch_i);
    e_req = m_hold || (req_i && (m_started || branch_i) && occ < N);
    chk("instr_req", instr_req_o, e_req);
    chk("busy", busy_o, e_req || occ != 0);
    if (branch_i) begin
      m_epoch++;
      expq.delete();
      m_rsp = {addr_i[31:1], 1'b0};
      m_fetch = al(addr_i);
      m_started = 1'b1;
    end
    if (e_req) chk("instr_addr", instr_addr_o, m_fetch);
    if (instr_rvalid_i && outq.size() > 0) begin
      e = outq.pop_front();
      if (e.ep == m_epoch && !branch_i) begin
        w.addr = m_rsp; w.data = mem(e.addr);
        expq.push_back(w);
        m_rsp = al(m_rsp) + 32'd4;
      end
    end
    if (branch_i) begin
      chk("fifo_valid_branch", fifo_valid_o, 1'b0);
    end else if (fifo_valid_o) begin
      if (expq.size() == 0) begin
        chk("fifo_valid_spurious", fifo_valid_o, 1'b0);
      end else begin
        chk("fifo_addr", fifo_addr_o, expq[0].addr);
        chk("fifo_rdata", fifo_rdata_o, expq[0].data);
        if (fifo_ready_i) void'(expq.pop_front());
      end
    end else if (fifo_ready_i && expq.size() > 0) begin
      chk("fifo_stall", fifo_valid_o, 1'b1);
    end
    if (instr_req_o && instr_gnt_i) begin
      outq.push_back('{addr: instr_addr_o, ep: m_epoch});
      m_fetch = al(instr_addr_o) + 32'd4;
    end
    m_hold = e_req && !instr_gnt_i;
    chk("occupancy_le_N", 32'(outq.size() + expq.size() <= N), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt[14];
    vec_t v;
    int unsigned grants;

    vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0};
    vt[1]  = '{1'b1, 1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      1'b0, 32'h0,        32'h0,        1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hD0D0D0D0, 1'b1, 1'b1, 32'h104,      1'b1, 32'h100,      32'hD0D0D0D0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hD1D1D1D1, 1'b1, 1'b0, 32'h108,      1'b1, 32'h104,      32'hD1D1D1D1, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h108,      1'b0, 32'h0,        32'h0,        1'b0};
    vt[5]  = '{1'b1, 1'b1, 32'h202,      1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        32'h0,        1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hD2D2D2D2, 1'b1, 1'b1, 32'h204,      1'b1, 32'h202,      32'hD2D2D2D2, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hD3D3D3D3, 1'b1, 1'b0, 32'h208,      1'b1, 32'h204,      32'hD3D3D3D3, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h208,      1'b0, 32'h0,        32'h0,        1'b0};
    vt[9]  = '{1'b1, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        32'h0,        1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1};
    vt[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hD4D4D4D4, 1'b1, 1'b0, 32'h4,        1'b1, 32'hFFFFFFFC, 32'hD4D4D4D4, 1'b1};
    vt[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hD5D5D5D5, 1'b1, 1'b0, 32'h4,        1'b1, 32'h0,        32'hD5D5D5D5, 1'b1};
    vt[13] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4,        1'b0, 32'h0,        32'h0,        1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req", instr_req_o, 1'b0);
    chk("rst_fvalid", fifo_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_iaddr", instr_addr_o, 32'h0);
    rst_n = 1'b1;

    // Vector table: boot jump, unaligned target, address wrap.
    for (int i = 0; i < 14; i++) begin
      v = vt[i];
      drive(v.rq, v.br, v.a, v.g, v.rv, v.d, v.rd);
      chk($sformatf("vec%0d_req", i), instr_req_o, v.e_req);
      chk($sformatf("vec%0d_iaddr", i), instr_addr_o, v.e_iaddr);
      chk($sformatf("vec%0d_fvalid", i), fifo_valid_o, v.e_fv);
      chk($sformatf("vec%0d_clear", i), fifo_clear_o, v.br);
      chk($sformatf("vec%0d_busy", i), busy_o, v.e_busy);
      if (v.e_fv) begin
        chk($sformatf("vec%0d_faddr", i), fifo_addr_o, v.e_faddr);
        chk($sformatf("vec%0d_fdata", i), fifo_rdata_o, v.e_fdata);
      end
    end

    // Branch while two requests are outstanding and the first response arrives.
    drive(1, 1, 32'h100, 1, 0, 0, 1);
    drive(1, 0, 0, 1, 0, 0, 1);
    chk("bA_second_addr", instr_addr_o, 32'h104);
    drive(1, 1, 32'h400, 0, 1, mem(32'h100), 1);
    chk("bA_clear", fifo_clear_o, 1'b1);
    chk("bA_fv_branch", fifo_valid_o, 1'b0);
    chk("bA_req_full", instr_req_o, 1'b0);
    drive(1, 0, 0, 1, 1, mem(32'h104), 1);
    chk("bA_drop_old", fifo_valid_o, 1'b0);
    chk("bA_clear_once", fifo_clear_o, 1'b0);
    chk("bA_req_target", instr_req_o, 1'b1);
    chk("bA_iaddr_target", instr_addr_o, 32'h400);
    drive(0, 0, 0, 0, 1, mem(32'h400), 1);
    chk("bA_first_live_v", fifo_valid_o, 1'b1);
    chk("bA_first_live_a", fifo_addr_o, 32'h400);
    chk("bA_first_live_d", fifo_rdata_o, mem(32'h400));
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("bA_idle_busy", busy_o, 1'b0);

    // Back-pressure: at most N grants while the FIFO is not ready.
    grants = 0;
    drive(1, 1, 32'h500, 1, 0, 0, 0);
    if (instr_req_o && instr_gnt_i) grants++;
    drive(1, 0, 0, 1, 1, mem(32'h500), 0);
    chk("bB_no_bypass", fifo_valid_o, 1'b0);
    if (instr_req_o && instr_gnt_i) grants++;
    drive(1, 0, 0, 1, 1, mem(32'h504), 0);
    if (instr_req_o && instr_gnt_i) grants++;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 1, 0, 0, 0);
      if (instr_req_o && instr_gnt_i) grants++;
      chk("bB_req_low", instr_req_o, 1'b0);
      chk("bB_head_a", fifo_addr_o, 32'h500);
    end
    chk("bB_grants", grants, N);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("bB_pop0_v", fifo_valid_o, 1'b1);
    chk("bB_pop0_a", fifo_addr_o, 32'h500);
    chk("bB_pop0_d", fifo_rdata_o, mem(32'h500));
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("bB_pop1_a", fifo_addr_o, 32'h504);
    chk("bB_pop1_d", fifo_rdata_o, mem(32'h504));
    chk("bB_resume", instr_req_o, 1'b1);
    chk("bB_resume_a", instr_addr_o, 32'h508);
    drive(0, 0, 0, 1, 0, 0, 1);
    chk("bB_hold", instr_req_o, 1'b1);
    drive(0, 0, 0, 0, 1, mem(32'h508), 1);
    chk("bB_next_a", fifo_addr_o, 32'h508);
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("bB_idle_busy", busy_o, 1'b0);

`ifdef FETCH_ERR_EN
    // Error response blocks further requests until a branch.
    drive_e(1, 1, 32'h300, 1, 0, 0, 1, 0);
    drive_e(1, 0, 0, 1, 1, mem(32'h300), 1, 1);
    chk("err_word_a", fifo_addr_o, 32'h300);
    chk("err_flag", fifo_err_o, 1'b1);
    drive_e(1, 0, 0, 1, 1, mem(32'h304), 1, 0);
    chk("err_drain_v", fifo_valid_o, 1'b1);
    chk("err_drain_flag", fifo_err_o, 1'b0);
    chk("err_blocked0", instr_req_o, 1'b0);
    drive_e(1, 0, 0, 1, 0, 0, 1, 0);
    chk("err_blocked1", instr_req_o, 1'b0);
    drive_e(1, 1, 32'h600, 1, 0, 0, 1, 0);
    chk("err_unblock", instr_req_o, 1'b1);
    chk("err_unblock_a", instr_addr_o, 32'h600);
    drive_e(0, 0, 0, 0, 1, mem(32'h600), 1, 0);
    chk("err_after_a", fifo_addr_o, 32'h600);
`endif

    // Mid-run reset, then randomized traffic against the model.
    @(negedge clk);
    rst_n = 1'b0;
    apply(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst2_busy", busy_o, 1'b0);
    chk("rst2_fvalid", fifo_valid_o, 1'b0);
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ba;
      logic        rv;
      case ($urandom_range(2))
        0:       ba = $urandom;
        1:       ba = 32'hFFFFFFF0 | ($urandom & 32'hF);
        default: ba = ($urandom & 32'h0000FFFE);
      endcase
      rv = (outq.size() > 0) && ($urandom_range(99) < 55);
      @(posedge clk); #1;
      apply($urandom_range(99) < 85, $urandom_range(99) < 6, ba, $urandom_range(99) < 60,
            rv, rv ? mem(outq[0].addr) : $urandom, $urandom_range(99) < 70);
      @(negedge clk);
      model_step();
    end

    // Drain with bounded wait.
    for (int k = 0; k < 40; k++) begin
      logic rv;
      if (!busy_o && expq.size() == 0) break;
      rv = (outq.size() > 0);
      @(posedge clk); #1;
      apply(0, 0, 0, 1, rv, rv ? mem(outq[0].addr) : 32'h0, 1);
      @(negedge clk);
      model_step();
    end
    @(posedge clk); #1;
    apply(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("drain_busy", busy_o, 1'b0);
    chk("drain_words", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_fetch_req_ctrl.md
Name: ibex_fetch_req_ctrl

Overview:
Upstream neighbour of the fetch FIFO. Issues word-aligned instruction-memory requests on a req/gnt/rvalid bus and tracks up to NUM_REQS outstanding transactions. Discards stale responses after a branch and forwards surviving words, with their addresses, into the fetch FIFO's in_* port. A small response buffer guarantees no granted word is lost while the FIFO is not ready.

Parameters:
NUM_REQS, 2, maximum outstanding (granted, not yet responded) requests plus buffered responses; legal 1..3.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_i  input  1  fetch enable; low stops new requests
branch_i  input  1  one-cycle redirect pulse
addr_i  input  32  branch target; bit 1 may be set, bit 0 ignored
busy_o  output  1  instr_req_o OR out_cnt!=0 OR buffer not empty
instr_req_o  output  1  memory request
instr_addr_o  output  32  request address, bits[1:0]=00
instr_gnt_i  input  1  request accepted
instr_rvalid_i  input  1  response valid; one per grant, in order
instr_rdata_i  input  32  response data
fifo_valid_o  output  1  to FIFO in_valid_i
fifo_ready_i  input  1  from FIFO in_ready_o
fifo_addr_o  output  32  to FIFO in_addr_i
fifo_rdata_o  output  32  to FIFO in_rdata_i
fifo_clear_o  output  1  to FIFO clear_i; equals branch_i

Behaviour:
- Reset: instr_req_o=0, fetch_addr=0, rsp_addr=0, out_cnt=0, disc_cnt=0, buffer empty. fifo_valid_o=0, busy_o=0. Nothing is fetched until the first branch_i (boot jump).
- Issue condition: req_i AND (out_cnt + buf_cnt) < NUM_REQS. Once instr_req_o is high, it is held until instr_gnt_i, even if req_i drops or the issue condition fails.
- instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr. A branch while waiting for a grant retargets the pending request in the same cycle.
- On a grant, fetch_addr <= instr_addr_o + 4, modulo 2^32 (0xFFFFFFFC wraps to 0). out_cnt increments.
- On instr_rvalid_i with out_cnt>0, out_cnt decrements:
  - If disc_cnt>0: drop the word and decrement disc_cnt.
  - Otherwise: the word is a live response tagged with rsp_addr, and rsp_addr <= {rsp_addr[31:2]+1,2'b00}.
- A response with out_cnt==0 is ignored. This covers bus traffic arriving after a mid-operation reset.
- Live response path, FIFO order preserved:
  - Buffer empty and fifo_ready_i: bypass. fifo_valid_o, fifo_rdata_o and fifo_addr_o are driven combinationally from instr_rdata_i/rsp_addr in the same cycle, with zero latency.
  - Otherwise: the response is written to the buffer (depth NUM_REQS). The buffer head drives the fifo_* outputs, and a pop occurs when fifo_valid_o AND fifo_ready_i.
- Simultaneous pop and push: the buffer count is unchanged.
- The buffer can never overflow: the issue condition reserves space. The bench asserts this.
- Branch cycle:
  - fifo_clear_o=1, fifo_valid_o=0, buffer flushed.
  - disc_cnt <= out_cnt - (instr_rvalid_i ? 1 : 0), so every older response is dropped, including one arriving this cycle.
  - rsp_addr <= {addr_i[31:1],1'b0}; bit 1 is kept so the FIFO handles an unaligned start.
  - A grant in the branch cycle is for the target and is counted live.
- Back-to-back branches: each branch re-evaluates disc_cnt from the current out_cnt.

Optional Feature:
FETCH_ERR_EN:
- Defined: adds instr_err_i (input, 1, bus error qualifying rvalid) and fifo_err_o (output, 1). The buffer stores 33 bits, and the error bit travels with its word. After a live erroneous response, the block issues no further requests until the next branch_i; outstanding responses still drain.
- Undefined: neither port exists and the buffer stores 32 bits.

Test Plan:
- Reset, then branch_i with addr_i=0x100, req_i=1, gnt immediate, fifo_ready_i=1 -> instr_addr_o 0x100, 0x104. FIFO receives 0x100/0x104 with rdata in order, zero latency.
- Unaligned branch to 0x202 -> first fifo_addr_o=0x202, next 0x204. instr_addr_o=0x200.
- Two requests outstanding, then branch to 0x400 while the first rvalid is arriving -> both old words dropped, disc_cnt reaches 0. The first FIFO word is from 0x400, and fifo_clear_o pulses once.
- fifo_ready_i=0 with NUM_REQS=2 -> at most 2 grants, instr_req_o low afterwards. Raising ready drains 2 words in order, then issue resumes.
- Branch to 0xFFFFFFFC with 2 grants -> instr_addr_o 0xFFFFFFFC then 0x00000000.
- FETCH_ERR_EN: error response at 0x300 -> fifo_err_o=1 with that word and no further instr_req_o until branch_i.
